// File: rtl/trap_controller.sv
// Machine-mode trap and system-instruction responder for the RV32 core:
// machine CSRs, trap/return redirects, FENCE drain stall and EBREAK halt.
module trap_controller #(
  parameter int              XLEN           = 32,
  parameter int              FENCE_CYCLES   = 2,
  parameter int              HALT_ON_EBREAK = 0,
  parameter logic [XLEN-1:0] MTVEC_RESET    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            instr_ecall,
  input  logic            instr_ebreak,
  input  logic            instr_fence,
  input  logic            instr_mret,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            stall,
  output logic            halted,
  input  logic            resume,
  output logic            illegal_csr
);

  typedef enum logic [1:0] {RUN, FENCE_WAIT, HALT} state_t;

  localparam int            CW         = (FENCE_CYCLES > 1) ? $clog2(FENCE_CYCLES) : 1;
  localparam logic [CW-1:0] FENCE_LOAD = CW'((FENCE_CYCLES > 0) ? FENCE_CYCLES - 1 : 0);
  localparam logic          HALT_EN    = (HALT_ON_EBREAK != 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
  logic            resume_pulse;

  logic            csr_known, accepted;
  logic            do_halt, do_trap, do_mret, do_fence, do_csr;
  logic [XLEN-1:0] cause, csr_new;

  always_comb begin
    csr_rdata = '0;
    csr_known = 1'b1;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3] = mie;
        csr_rdata[7] = mpie;
      end
      12'h305: csr_rdata = mtvec;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      default: csr_known = 1'b0;
    endcase
  end

  // The resume redirect cycle owns the PC, so nothing retires alongside it.
  assign accepted    = rst_n && instr_valid && (state == RUN) && !resume_pulse;
  assign illegal_csr = accepted && csr_en && !csr_known;

  always_comb begin
    do_halt  = accepted && !illegal_csr && instr_ebreak && HALT_EN;
    do_trap  = accepted && !do_halt && (illegal_csr || instr_ebreak || instr_ecall);
    do_mret  = accepted && !do_halt && !do_trap && instr_mret;
    do_fence = accepted && !do_halt && !do_trap && !do_mret && instr_fence;
    do_csr   = accepted && csr_en && !do_halt && !do_trap && !do_mret && !do_fence
               && (csr_op != 2'b00);
    if (illegal_csr)       cause = XLEN'(2);
    else if (instr_ebreak) cause = XLEN'(3);
    else                   cause = XLEN'(11);
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  always_comb begin
    trap_redirect = resume_pulse || do_trap || do_mret;
    trap_pc       = '0;
    if (resume_pulse)  trap_pc = mepc + XLEN'(4);
    else if (do_trap)  trap_pc = mtvec;
    else if (do_mret)  trap_pc = mepc;
  end

  assign stall  = (state != RUN);
  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      mie          <= 1'b0;
      mpie         <= 1'b0;
      mtvec        <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      resume_pulse <= 1'b0;
    end else begin
      resume_pulse <= (state == HALT) && resume;
      case (state)
        RUN: begin
          if (do_halt) begin
            state  <= HALT;
            mepc   <= {pc[XLEN-1:2], 2'b00};
            mcause <= XLEN'(3);
          end else if (do_trap) begin
            mepc   <= {pc[XLEN-1:2], 2'b00};
            mcause <= cause;
            mpie   <= mie;
            mie    <= 1'b0;
          end else if (do_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
          end else if (do_fence) begin
            if (FENCE_CYCLES > 0) begin
              state <= FENCE_WAIT;
              cnt   <= FENCE_LOAD;
            end
          end else if (do_csr) begin
            case (csr_addr)
              12'h300: begin
                mie  <= csr_new[3];
                mpie <= csr_new[7];
              end
              12'h305: mtvec    <= {csr_new[XLEN-1:2], 2'b00};
              12'h340: mscratch <= csr_new;
              12'h341: mepc     <= {csr_new[XLEN-1:2], 2'b00};
              12'h342: mcause   <= csr_new;
              default: ;
            endcase
          end
        end
        FENCE_WAIT: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - CW'(1);
        end
        HALT: begin
          if (resume) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: one trapping instance and one
// halt-on-EBREAK instance share the stimulus; each is checked where relevant.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ecall, instr_ebreak, instr_fence, instr_mret;
  logic [31:0] pc;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        resume;

  logic [31:0] a_rdata, a_tpc, b_rdata, b_tpc;
  logic        a_redir, a_stall, a_halted, a_ill;
  logic        b_redir, b_stall, b_halted, b_ill;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(32), .FENCE_CYCLES(2), .HALT_ON_EBREAK(0),
                    .MTVEC_RESET(32'h0000_0207)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc),
    .instr_ecall(instr_ecall), .instr_ebreak(instr_ebreak),
    .instr_fence(instr_fence), .instr_mret(instr_mret),
    .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(a_rdata), .trap_redirect(a_redir), .trap_pc(a_tpc),
    .stall(a_stall), .halted(a_halted), .resume(resume), .illegal_csr(a_ill));

  trap_controller #(.XLEN(32), .FENCE_CYCLES(2), .HALT_ON_EBREAK(1),
                    .MTVEC_RESET(32'h0000_0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc),
    .instr_ecall(instr_ecall), .instr_ebreak(instr_ebreak),
    .instr_fence(instr_fence), .instr_mret(instr_mret),
    .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(b_rdata), .trap_redirect(b_redir), .trap_pc(b_tpc),
    .stall(b_stall), .halted(b_halted), .resume(resume), .illegal_csr(b_ill));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_valid = 0; instr_ecall = 0; instr_ebreak = 0; instr_fence = 0;
    instr_mret = 0; csr_en = 0; csr_op = 2'b00; csr_wdata = '0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    idle();
    instr_valid = 1; csr_en = 1; csr_addr = a; csr_op = op; csr_wdata = d;
    #1;
  endtask

  initial begin
    idle();
    pc = '0; csr_addr = 12'h300; rst_n = 0;
    #3;
    chk("rst_stall",  {31'b0, a_stall},  32'h0);
    chk("rst_halted", {31'b0, b_halted}, 32'h0);
    chk("rst_redir",  {31'b0, a_redir},  32'h0);
    #9 rst_n = 1;
    tick();

    csr_addr = 12'h300; #1 chk("rst_mstatus",  a_rdata, 32'h0);
    csr_addr = 12'h305; #1 chk("rst_mtvec_a",  a_rdata, 32'h0000_0204);
    chk("rst_mtvec_b", b_rdata, 32'h0);
    csr_addr = 12'h340; #1 chk("rst_mscratch", a_rdata, 32'h0);
    csr_addr = 12'h341; #1 chk("rst_mepc",     a_rdata, 32'h0);
    csr_addr = 12'h342; #1 chk("rst_mcause",   a_rdata, 32'h0);
    tick();

    csr_wr(12'h305, 2'b01, 32'h0000_0103);
    chk("mtvec_old", a_rdata, 32'h0000_0204);
    tick();
    csr_wr(12'h300, 2'b10, 32'h0000_0008);
    chk("mstatus_old", a_rdata, 32'h0);
    tick();
    csr_wr(12'h340, 2'b01, 32'hFFFF_FFFF);
    tick();
    csr_wr(12'h340, 2'b11, 32'h0F0F_0000);
    tick();
    idle(); csr_addr = 12'h340; #1 chk("mscratch_clr", a_rdata, 32'hF0F0_FFFF);
    csr_addr = 12'h305; #1 chk("mtvec_new", a_rdata, 32'h0000_0100);

    idle(); instr_valid = 1; instr_ecall = 1; pc = 32'h40;
    #1 chk("ecall_redir", {31'b0, a_redir}, 32'h1);
    chk("ecall_tpc", a_tpc, 32'h0000_0100);
    tick(); idle();
    csr_addr = 12'h341; #1 chk("ecall_mepc",    a_rdata, 32'h40);
    csr_addr = 12'h342; #1 chk("ecall_mcause",  a_rdata, 32'd11);
    csr_addr = 12'h300; #1 chk("ecall_mstatus", a_rdata, 32'h80);

    instr_valid = 1; instr_mret = 1;
    #1 chk("mret_redir", {31'b0, a_redir}, 32'h1);
    chk("mret_tpc", a_tpc, 32'h40);
    tick(); idle();
    #1 chk("mret_mstatus", a_rdata, 32'h88);

    instr_valid = 1; instr_fence = 1; pc = 32'h44;
    #1 chk("fence_T_stall", {31'b0, a_stall}, 32'h0);
    tick(); idle();
    instr_valid = 1; instr_ecall = 1; pc = 32'h48;
    #1 chk("fence_T1_stall", {31'b0, a_stall}, 32'h1);
    chk("fence_T1_redir", {31'b0, a_redir}, 32'h0);
    tick();
    chk("fence_T2_stall", {31'b0, a_stall}, 32'h1);
    chk("fence_T2_redir", {31'b0, a_redir}, 32'h0);
    tick(); idle();
    chk("fence_T3_stall", {31'b0, a_stall}, 32'h0);
    csr_addr = 12'h341; #1 chk("fence_mepc_kept", a_rdata, 32'h40);

    csr_wr(12'h7C0, 2'b01, 32'hDEAD_BEEF);
    pc = 32'h80;
    #1 chk("ill_flag", {31'b0, a_ill}, 32'h1);
    chk("ill_redir", {31'b0, a_redir}, 32'h1);
    chk("ill_tpc", a_tpc, 32'h0000_0100);
    tick(); idle();
    csr_addr = 12'h342; #1 chk("ill_mcause",   a_rdata, 32'd2);
    csr_addr = 12'h341; #1 chk("ill_mepc",     a_rdata, 32'h80);
    csr_addr = 12'h340; #1 chk("ill_mscratch", a_rdata, 32'hF0F0_FFFF);
    csr_addr = 12'h305; #1 chk("ill_mtvec",    a_rdata, 32'h0000_0100);

    instr_valid = 1; instr_ebreak = 1; pc = 32'hFFFF_FFFC;
    #1 chk("halt_T_redir",  {31'b0, b_redir},  32'h0);
    chk("halt_T_halted", {31'b0, b_halted}, 32'h0);
    tick(); idle();
    chk("halt_halted", {31'b0, b_halted}, 32'h1);
    chk("halt_stall",  {31'b0, b_stall},  32'h1);
    csr_addr = 12'h342; #1 chk("halt_mcause", b_rdata, 32'd3);
    csr_addr = 12'h341; #1 chk("halt_mepc",   b_rdata, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) tick();
    chk("halt_hold", {31'b0, b_halted}, 32'h1);
    resume = 1;
    tick(); resume = 0;
    #1 chk("resume_halted", {31'b0, b_halted}, 32'h0);
    chk("resume_stall", {31'b0, b_stall}, 32'h0);
    chk("resume_redir", {31'b0, b_redir}, 32'h1);
    chk("resume_tpc",   b_tpc, 32'h0000_0000);
    tick();
    chk("resume_pulse_end", {31'b0, b_redir}, 32'h0);

    instr_valid = 1; instr_ebreak = 1; pc = 32'h10;
    tick(); idle();
    chk("halt2_halted", {31'b0, b_halted}, 32'h1);
    rst_n = 0;
    #1 chk("halt2_rst_halted", {31'b0, b_halted}, 32'h0);
    chk("halt2_rst_stall", {31'b0, b_stall}, 32'h0);
    #2 rst_n = 1;
    tick();
    csr_addr = 12'h342; #1 chk("post_rst_mcause", b_rdata, 32'h0);
    csr_addr = 12'h305; #1 chk("post_rst_mtvec",  a_rdata, 32'h0000_0204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap and system-instruction responder for the RV32 single-cycle core. Consumes the system-instruction strobes produced by instruction decode (ECALL, EBREAK, FENCE, MRET, CSR access) and acts on them. It holds the machine CSRs, redirects the PC on traps and returns, stalls the core for FENCE drain, and optionally halts on EBREAK until resumed.

## Interface
- XLEN, 32, data/address width
- FENCE_CYCLES, 2, stall cycles inserted after a retired FENCE (0 = no stall)
- HALT_ON_EBREAK, 0, 1 = EBREAK halts the core instead of trapping
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction in decode retires this cycle
- pc  in  XLEN  PC of that instruction
- instr_ecall / instr_ebreak / instr_fence / instr_mret  in  1 each  decode strobes
- csr_en  in  1  CSR instruction this cycle
- csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  write value / bit mask
- csr_rdata  out  XLEN  old CSR value, combinational
- trap_redirect  out  1  PC must load trap_pc this cycle
- trap_pc  out  XLEN  redirect target
- stall  out  1  hold PC and suppress register/memory writes
- halted  out  1  core halted on EBREAK
- resume  in  1  leave halt (level, sampled in HALT only)
- illegal_csr  out  1  csr_en with an unimplemented address

## Operation
- CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - mtvec 0x305: direct mode only; [1:0] read 0.
  - mscratch 0x340: full width.
  - mepc 0x341: [1:0] read 0.
  - mcause 0x342: full width.
- Accepted event: instr_valid=1, stall=0, state RUN. Non-accepted cycles change no state.
- Priority when strobes collide: illegal_csr > ebreak > ecall > mret > fence > csr.
- CSR access: csr_rdata = current value. Next value is wdata, old|wdata or old&~wdata per csr_op; 00 writes nothing.
- Trap entry (ecall cause 11, ebreak cause 3, illegal CSR cause 2):
  - Updates: mepc<=pc, mcause<=cause, MPIE<=MIE, MIE<=0.
  - Outputs: trap_redirect=1, trap_pc=mtvec in the same cycle.
  - A trapping CSR access performs no CSR write.
- MRET: trap_redirect=1, trap_pc=mepc; MIE<=MPIE, MPIE<=1.
- FSM states RUN, FENCE_WAIT, HALT:
  - RUN -> FENCE_WAIT on accepted fence when FENCE_CYCLES>0; counter loads FENCE_CYCLES-1.
  - FENCE_WAIT: stall=1; counter decrements each cycle; at 0 -> RUN.
  - RUN -> HALT on accepted ebreak when HALT_ON_EBREAK=1. On entry mepc<=pc, mcause<=3, MIE unchanged, no redirect.
  - HALT: stall=1, halted=1. resume=1 -> RUN, and in the next cycle trap_redirect=1, trap_pc=mepc+4 (one-cycle registered pulse).
- Reset (any time, including mid-HALT or mid-FENCE_WAIT): state RUN, counter 0, all CSRs 0 except mtvec=MTVEC_RESET&~3. All outputs 0 except csr_rdata, which tracks the addressed CSR.

## Timing
- CSR read, trap_redirect and trap_pc are combinational from inputs and state. CSR updates are visible from the next cycle.
- The FENCE instruction itself retires in cycle T. stall is high for cycles T+1..T+FENCE_CYCLES exactly.
- HALT entry at edge after T; halted high from T+1.
- resume seen in cycle R: halted low from R+1, redirect pulse in R+1, stall low from R+1.
- Back-to-back traps are allowed every cycle; each overwrites mepc/mcause.
- mepc+4 wraps modulo 2^XLEN.

## Test plan
- Reset, then read all five CSRs -> mtvec=MTVEC_RESET, others 0; stall=halted=trap_redirect=0.
- Write mtvec=0x0000_0103, set mstatus mask 0x8, then ecall at pc=0x40:
  - same cycle: redirect to 0x100;
  - next cycle: mepc=0x40, mcause=11, mstatus=0x80.
- MRET after that trap -> redirect to 0x40; mstatus=0x88.
- FENCE_CYCLES=2, fence at T -> stall high in T+1 and T+2 only; an instr_valid ecall during stall causes no redirect.
- HALT_ON_EBREAK=1, ebreak at pc=0xFFFF_FFFC -> halted; resume after 5 cycles -> redirect pulse to 0x0000_0000. Assert rst_n low during a second halt -> halted drops immediately.
- csr_en with csr_addr=0x7C0 and op 01 -> illegal_csr=1, redirect to mtvec, mcause=2, no CSR modified.
